// File: rtl/multicycle_ctrl_ws.sv
// Multicycle control unit with memory wait states, bus timeout fault,
// flag-selected conditional jump, HALT and a retired-instruction counter.
module multicycle_ctrl_ws #(
  parameter int unsigned NFLAGS  = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned JSEL_W = $clog2(NFLAGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [JSEL_W-1:0] jsel,
  input  logic [NFLAGS-1:0] flags,
  input  logic              mem_rdy,
  output logic              pc_src,
  output logic              pc_out,
  output logic              ir_ld_r,
  output logic              ir_ld_l,
  output logic              reg_sel,
  output logic              ir_d_out,
  output logic              ir_a_out,
  output logic              m_out,
  output logic              m_ld,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_file_sel,
  output logic              r_out,
  output logic              r_ld,
  output logic              di_ld,
  output logic              a_ld,
  output logic              b_ld,
  output logic              alu_res_out,
  output logic              alu_res_ld,
  output logic              czn_ld,
  output logic              pc_ld_en,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned NSEL = 1 << JSEL_W;

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_IF1, S_IF2, S_ID,
    S_RT1, S_RT2, S_RT3, S_RT4, S_RT5, S_RT6,
    S_IF3, S_IF4, S_LDA1, S_LDA2, S_STA1, S_STA2, S_JMP,
    S_ADA1, S_ADA2, S_ADA3, S_ADA4, S_ADA5, S_ADA6,
    S_HALT, S_FAULT
  } state_t;

  state_t            state, state_nx;
  logic [WC_W-1:0]   wcnt;
  logic              is_wait;
  logic              tmo;
  logic              pc_ld;
  logic              jump;
  logic              jump_cond;
  logic              retire;
  logic [NSEL-1:0]   cond_vec;

  // Condition select: slot 0 is "always", slots beyond NFLAGS read as never
  always_comb begin
    cond_vec  = NSEL'({flags, 1'b1});
    jump_cond = cond_vec[jsel];
  end

  // Wait-state detection and timeout (mem_rdy in the same cycle takes priority)
  always_comb begin
    is_wait = (state == S_IF2) || (state == S_IF4) || (state == S_LDA2) ||
              (state == S_STA2) || (state == S_ADA2);
    tmo     = (TIMEOUT != 0) && is_wait && !mem_rdy &&
              (wcnt == WC_W'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Wait counter: cleared on every state change, counts stalled wait cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         wcnt <= '0;
    else if (state_nx != state)      wcnt <= '0;
    else if (is_wait && !mem_rdy)    wcnt <= wcnt + WC_W'(1);
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nx     = state;
    pc_src       = 1'b0;
    pc_out       = 1'b0;
    ir_ld_r      = 1'b0;
    ir_ld_l      = 1'b0;
    reg_sel      = 1'b0;
    ir_d_out     = 1'b0;
    ir_a_out     = 1'b0;
    m_out        = 1'b0;
    m_ld         = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_file_sel = 1'b0;
    r_out        = 1'b0;
    r_ld         = 1'b0;
    di_ld        = 1'b0;
    a_ld         = 1'b0;
    b_ld         = 1'b0;
    alu_res_out  = 1'b0;
    alu_res_ld   = 1'b0;
    czn_ld       = 1'b0;
    pc_ld        = 1'b0;
    jump         = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE:  if (start)  state_nx = S_START;
      S_START: if (!start) state_nx = S_IF1;
      S_IF1: begin
        pc_out = 1'b1; pc_ld = 1'b1; m_ld = 1'b1;
        state_nx = S_IF2;
      end
      S_IF2: begin
        m_out = 1'b1;
        if (mem_rdy) begin
          ir_ld_l  = 1'b1;
          state_nx = S_ID;
        end else if (tmo) begin
          state_nx = S_FAULT;
        end
      end
      S_ID: begin
        casez (opcode)
          4'b10??: state_nx = S_RT1;
          4'b1110: begin
            ir_d_out = 1'b1; di_ld = 1'b1; retire = 1'b1;
            state_nx = S_IF1;
          end
          4'b1111: begin
            retire   = 1'b1;
            state_nx = S_HALT;
          end
          default: state_nx = S_IF3;
        endcase
      end
      S_RT1: begin reg_file_sel = 1'b1; r_ld = 1'b1; state_nx = S_RT2; end
      S_RT2: begin r_out = 1'b1; a_ld = 1'b1; state_nx = S_RT3; end
      S_RT3: begin
        reg_sel = 1'b1; reg_file_sel = 1'b1; r_ld = 1'b1;
        state_nx = S_RT4;
      end
      S_RT4: begin r_out = 1'b1; b_ld = 1'b1; state_nx = S_RT5; end
      S_RT5: begin alu_res_ld = 1'b1; czn_ld = 1'b1; state_nx = S_RT6; end
      S_RT6: begin
        alu_res_out = 1'b1; reg_write = 1'b1; reg_sel = 1'b1;
        reg_file_sel = 1'b1; retire = 1'b1;
        state_nx = S_IF1;
      end
      S_IF3: begin
        pc_out = 1'b1; pc_ld = 1'b1; m_ld = 1'b1;
        state_nx = S_IF4;
      end
      S_IF4: begin
        m_out = 1'b1;
        if (mem_rdy) begin
          ir_ld_r = 1'b1;
          casez (opcode)
            4'b000?: state_nx = S_LDA1;
            4'b001?: state_nx = S_STA1;
            4'b110?: state_nx = S_JMP;
            default: state_nx = S_ADA1;
          endcase
        end else if (tmo) begin
          state_nx = S_FAULT;
        end
      end
      S_LDA1: begin ir_a_out = 1'b1; m_ld = 1'b1; state_nx = S_LDA2; end
      S_LDA2: begin
        m_out = 1'b1;
        if (mem_rdy) begin
          reg_write = 1'b1; retire = 1'b1;
          state_nx = S_IF1;
        end else if (tmo) begin
          state_nx = S_FAULT;
        end
      end
      S_STA1: begin r_ld = 1'b1; state_nx = S_STA2; end
      S_STA2: begin
        r_out = 1'b1; ir_a_out = 1'b1; mem_write = 1'b1;
        if (mem_rdy) begin
          retire   = 1'b1;
          state_nx = S_IF1;
        end else if (tmo) begin
          state_nx = S_FAULT;
        end
      end
      S_JMP: begin
        ir_a_out = 1'b1; pc_src = 1'b1; jump = 1'b1; retire = 1'b1;
        state_nx = S_IF1;
      end
      S_ADA1: begin ir_a_out = 1'b1; m_ld = 1'b1; state_nx = S_ADA2; end
      S_ADA2: begin
        m_out = 1'b1;
        if (mem_rdy) begin
          a_ld     = 1'b1;
          state_nx = S_ADA3;
        end else if (tmo) begin
          state_nx = S_FAULT;
        end
      end
      S_ADA3: begin r_ld = 1'b1; state_nx = S_ADA4; end
      S_ADA4: begin r_out = 1'b1; b_ld = 1'b1; state_nx = S_ADA5; end
      S_ADA5: begin alu_res_ld = 1'b1; czn_ld = 1'b1; state_nx = S_ADA6; end
      S_ADA6: begin
        alu_res_out = 1'b1; reg_write = 1'b1; retire = 1'b1;
        state_nx = S_IF1;
      end
      S_HALT:  state_nx = S_HALT;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
    pc_ld_en = pc_ld | (jump & jump_cond);
  end

  // ALU operation from opcode; forced to 0 in IDLE so reset leaves every output low
  always_comb begin
    alu_op = 2'd0;
    if (state != S_IDLE) begin
      casez (opcode)
        4'b010?, 4'b1001: alu_op = 2'd3;
        4'b011?, 4'b1010: alu_op = 2'd1;
        4'b1011:          alu_op = 2'd2;
        default:          alu_op = 2'd0;
      endcase
    end
  end

  // Status flags from the registered state
  always_comb begin
    busy   = !((state == S_IDLE) || (state == S_START) ||
               (state == S_HALT) || (state == S_FAULT));
    halted = (state == S_HALT);
    fault  = (state == S_FAULT);
  end

endmodule
